// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, function fields, ALU operations and the decoded-entry bundle
// that travels from decode into execute.
package cpu_types_pkg;

    // Width of pc and imm inside the bundle; stages narrow or widen to their own XLEN.
    localparam int CPU_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [6:0] {
        RTYPE    = 7'b0110011,
        ITYPE    = 7'b0010011,
        ITYPE_LW = 7'b0000011,
        JALR     = 7'b1100111,
        STYPE    = 7'b0100011,
        BTYPE    = 7'b1100011,
        JAL      = 7'b1101111,
        LUI      = 7'b0110111,
        AUIPC    = 7'b0010111,
        LR_SC    = 7'b0101111,
        HALT     = 7'b1111111
    } opcode_t;

    typedef enum logic [2:0] {
        ADD_SUB = 3'b000, SLL = 3'b001, SLT = 3'b010, SLTU = 3'b011,
        XOR = 3'b100, SRL_SRA = 3'b101, OR = 3'b110, AND = 3'b111
    } funct3_r_t;

    typedef enum logic [2:0] {
        ADDI = 3'b000, SLLI = 3'b001, SLTI = 3'b010, SLTIU = 3'b011,
        XORI = 3'b100, SRLI_SRAI = 3'b101, ORI = 3'b110, ANDI = 3'b111
    } funct3_i_t;

    typedef enum logic [2:0] {
        BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100,
        BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111
    } funct3_b_t;

    typedef enum logic [4:0] {
        LR = 5'b00010,
        SC = 5'b00011
    } funct5_t;

    localparam logic [2:0] RDSEL_ALU   = 3'd0;
    localparam logic [2:0] RDSEL_MEM   = 3'd1;
    localparam logic [2:0] RDSEL_NPC   = 3'd2;
    localparam logic [2:0] RDSEL_LUI   = 3'd3;
    localparam logic [2:0] RDSEL_AUIPC = 3'd4;

    localparam logic [1:0] PCSRC_NPC    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JAL    = 2'd2;
    localparam logic [1:0] PCSRC_JALR   = 2'd3;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [CPU_XLEN-1:0] imm;
        aluop_t              aluop;
        logic                regwr;
        logic                dren;
        logic                dwen;
        logic                alusrc;
        logic                jpsel;
        logic                atomic;
        logic [1:0]          pcsrc;
        logic [2:0]          rdsel;
        logic                halt;
        logic                illegal;
    } decode_bundle_t;

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32 decoder: raw instruction word to control bundle with sign-extended
// immediate and illegal-instruction flag. The pc field is left zero for the caller to fill.
module rv32_decoder
    import cpu_types_pkg::*;
#(
    parameter int XLEN      = CPU_XLEN,
    parameter bit ATOMIC_EN = 1'b1
) (
    input  logic [31:0]    instr,
    output decode_bundle_t bundle
);

    opcode_t        opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [4:0]     funct5;
    logic           alt_ok;
    logic [31:0]    imm32;
    logic [XLEN-1:0] imm_x;
    decode_bundle_t d;

    assign opcode = opcode_t'(instr[6:0]);
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign funct5 = instr[31:27];
    assign alt_ok = (funct7 == 7'h00) || (funct7 == 7'h20);

    always_comb begin
        d       = '0;
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.rd    = instr[11:7];
        d.aluop = ALU_ADD;
        d.rdsel = RDSEL_ALU;
        imm32   = '0;
        case (opcode)
            RTYPE: begin
                d.regwr = 1'b1;
                case (funct3_r_t'(funct3))
                    ADD_SUB: d.aluop = funct7[5] ? ALU_SUB : ALU_ADD;
                    SLL:     d.aluop = ALU_SLL;
                    SLT:     d.aluop = ALU_SLT;
                    SLTU:    d.aluop = ALU_SLTU;
                    XOR:     d.aluop = ALU_XOR;
                    SRL_SRA: d.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                    OR:      d.aluop = ALU_OR;
                    default: d.aluop = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate encoding in funct7.
                if (funct3 == ADD_SUB || funct3 == SRL_SRA)
                    d.illegal = !alt_ok;
                else
                    d.illegal = (funct7 != 7'h00);
            end
            ITYPE: begin
                d.regwr  = 1'b1;
                d.alusrc = 1'b1;
                imm32    = {{20{instr[31]}}, instr[31:20]};
                case (funct3_i_t'(funct3))
                    ADDI:      d.aluop = ALU_ADD;
                    SLLI:      d.aluop = ALU_SLL;
                    SLTI:      d.aluop = ALU_SLT;
                    SLTIU:     d.aluop = ALU_SLTU;
                    XORI:      d.aluop = ALU_XOR;
                    SRLI_SRAI: begin
                        d.aluop   = funct7[5] ? ALU_SRA : ALU_SRL;
                        d.illegal = !alt_ok;
                    end
                    ORI:       d.aluop = ALU_OR;
                    default:   d.aluop = ALU_AND;
                endcase
            end
            ITYPE_LW: begin
                d.regwr  = 1'b1;
                d.dren   = 1'b1;
                d.alusrc = 1'b1;
                d.rdsel  = RDSEL_MEM;
                imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            JALR: begin
                d.regwr  = 1'b1;
                d.alusrc = 1'b1;
                d.jpsel  = 1'b1;
                d.pcsrc  = PCSRC_JALR;
                d.rdsel  = RDSEL_NPC;
                imm32    = {{20{instr[31]}}, instr[31:20]};
            end
            STYPE: begin
                d.dwen   = 1'b1;
                d.alusrc = 1'b1;
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            BTYPE: begin
                d.pcsrc = PCSRC_BRANCH;
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                case (funct3)
                    BEQ, BNE:   d.aluop = ALU_SUB;
                    BLT, BGE:   d.aluop = ALU_SLT;
                    BLTU, BGEU: d.aluop = ALU_SLTU;
                    default:    d.illegal = 1'b1;
                endcase
            end
            JAL: begin
                d.regwr = 1'b1;
                d.pcsrc = PCSRC_JAL;
                d.rdsel = RDSEL_NPC;
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            LUI: begin
                d.regwr = 1'b1;
                d.rdsel = RDSEL_LUI;
                imm32   = {instr[31:12], 12'b0};
            end
            AUIPC: begin
                d.regwr = 1'b1;
                d.rdsel = RDSEL_AUIPC;
                imm32   = {instr[31:12], 12'b0};
            end
            LR_SC: begin
                if (!ATOMIC_EN) begin
                    d.illegal = 1'b1;
                end else if (funct5 == LR) begin
                    d.regwr  = 1'b1;
                    d.dren   = 1'b1;
                    d.atomic = 1'b1;
                    d.rdsel  = RDSEL_MEM;
                end else if (funct5 == SC) begin
                    d.regwr  = 1'b1;
                    d.dwen   = 1'b1;
                    d.atomic = 1'b1;
                    d.rdsel  = RDSEL_MEM;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            HALT: begin
                if (instr == 32'hFFFF_FFFF) d.halt = 1'b1;
                else                        d.illegal = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        // Illegal entries must never write state or redirect the pc.
        if (d.illegal) begin
            d.regwr  = 1'b0;
            d.dren   = 1'b0;
            d.dwen   = 1'b0;
            d.atomic = 1'b0;
            d.halt   = 1'b0;
            d.pcsrc  = PCSRC_NPC;
        end
    end

    assign imm_x = XLEN'($signed(imm32));

    always_comb begin
        bundle     = d;
        bundle.imm = CPU_XLEN'($signed(imm_x));
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a 2-entry skid buffer (head H, skid S)
// with flush and sticky halt. All outputs come straight from the head register.
module decode_stage
    import cpu_types_pkg::*;
#(
    parameter int XLEN      = CPU_XLEN,
    parameter bit ATOMIC_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            in_ready,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output aluop_t          aluOp,
    output logic            regWr,
    output logic            dREN,
    output logic            dWEN,
    output logic            aluSrc,
    output logic            jpSel,
    output logic            atomic,
    output logic [1:0]      pcSrc,
    output logic [2:0]      rdSel,
    output logic            halt,
    output logic            illegal
);

    decode_bundle_t dec_bundle;
    decode_bundle_t entry;
    decode_bundle_t h_reg, h_next;
    decode_bundle_t s_reg, s_next;
    logic h_valid_reg, h_valid_next;
    logic s_valid_reg, s_valid_next;
    logic halt_pending_reg, halt_pending_next;
    logic halted_reg, halted_next;
    logic accept, pop;

    rv32_decoder #(
        .XLEN      (XLEN),
        .ATOMIC_EN (ATOMIC_EN)
    ) u_decoder (
        .instr  (in_instr),
        .bundle (dec_bundle)
    );

    always_comb begin
        entry    = dec_bundle;
        entry.pc = CPU_XLEN'(in_pc);
    end

    assign in_ready = !s_valid_reg && !halt_pending_reg && !halted_reg;
    assign accept   = in_valid && in_ready;
    assign pop      = h_valid_reg && out_ready;

    always_comb begin
        h_next            = h_reg;
        s_next            = s_reg;
        h_valid_next      = h_valid_reg;
        s_valid_next      = s_valid_reg;
        halt_pending_next = halt_pending_reg;
        halted_next       = halted_reg;
        if (flush) begin
            h_valid_next      = 1'b0;
            s_valid_next      = 1'b0;
            halt_pending_next = 1'b0;
        end else begin
            if (pop) begin
                // S valid implies in_ready was low, so no accept competes here.
                if (s_valid_reg) begin
                    h_next       = s_reg;
                    s_valid_next = 1'b0;
                end else if (accept) begin
                    h_next = entry;
                end else begin
                    h_valid_next = 1'b0;
                end
                if (h_reg.halt) begin
                    halt_pending_next = 1'b0;
                    halted_next       = 1'b1;
                end
            end else if (accept) begin
                if (!h_valid_reg) begin
                    h_next       = entry;
                    h_valid_next = 1'b1;
                end else begin
                    s_next       = entry;
                    s_valid_next = 1'b1;
                end
            end
            if (accept && entry.halt) halt_pending_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_reg            <= '0;
            s_reg            <= '0;
            h_valid_reg      <= 1'b0;
            s_valid_reg      <= 1'b0;
            halt_pending_reg <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            h_reg            <= h_next;
            s_reg            <= s_next;
            h_valid_reg      <= h_valid_next;
            s_valid_reg      <= s_valid_next;
            halt_pending_reg <= halt_pending_next;
            halted_reg       <= halted_next;
        end
    end

    assign out_valid = h_valid_reg;
    assign out_pc    = XLEN'(h_reg.pc);
    assign rs1       = h_reg.rs1;
    assign rs2       = h_reg.rs2;
    assign rd        = h_reg.rd;
    assign imm       = XLEN'($signed(h_reg.imm));
    assign aluOp     = h_reg.aluop;
    assign regWr     = h_reg.regwr;
    assign dREN      = h_reg.dren;
    assign dWEN      = h_reg.dwen;
    assign aluSrc    = h_reg.alusrc;
    assign jpSel     = h_reg.jpsel;
    assign atomic    = h_reg.atomic;
    assign pcSrc     = h_reg.pcsrc;
    assign rdSel     = h_reg.rdsel;
    assign halt      = h_reg.halt;
    assign illegal   = h_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of decode vectors plus hand-written
// back-pressure, flush, halt and atomic-disable sequences.
module tb_decode_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    aluop_t      aluOp;
    logic        regWr, dREN, dWEN, aluSrc, jpSel, atomic, halt, illegal;
    logic [1:0]  pcSrc;
    logic [2:0]  rdSel;

    logic        a0_in_ready, a0_out_valid;
    logic [31:0] a0_out_pc, a0_imm;
    logic [4:0]  a0_rs1, a0_rs2, a0_rd;
    aluop_t      a0_aluOp;
    logic        a0_regWr, a0_dREN, a0_dWEN, a0_aluSrc, a0_jpSel, a0_atomic, a0_halt, a0_illegal;
    logic [1:0]  a0_pcSrc;
    logic [2:0]  a0_rdSel;

    logic [11:0] ctl;
    assign ctl = {regWr, dREN, dWEN, aluSrc, jpSel, atomic, pcSrc, rdSel, illegal};

    always #5 CLK = ~CLK;

    decode_stage #(.XLEN(32), .ATOMIC_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .aluOp(aluOp),
        .regWr(regWr), .dREN(dREN), .dWEN(dWEN), .aluSrc(aluSrc), .jpSel(jpSel),
        .atomic(atomic), .pcSrc(pcSrc), .rdSel(rdSel), .halt(halt), .illegal(illegal)
    );

    decode_stage #(.XLEN(32), .ATOMIC_EN(1'b0)) dut_noatomic (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(a0_in_ready), .flush(flush), .out_ready(out_ready), .out_valid(a0_out_valid),
        .out_pc(a0_out_pc), .rs1(a0_rs1), .rs2(a0_rs2), .rd(a0_rd), .imm(a0_imm), .aluOp(a0_aluOp),
        .regWr(a0_regWr), .dREN(a0_dREN), .dWEN(a0_dWEN), .aluSrc(a0_aluSrc), .jpSel(a0_jpSel),
        .atomic(a0_atomic), .pcSrc(a0_pcSrc), .rdSel(a0_rdSel), .halt(a0_halt), .illegal(a0_illegal)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // ctl = {regWr,dREN,dWEN,aluSrc,jpSel,atomic, pcSrc[1:0], rdSel[2:0], illegal}
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        aluop_t      aluop;
        logic [11:0] ctl;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int pop_idx;
        int acc_idx;

        vecs[0]  = '{32'h002081B3, 5'd1, 5'd2,  5'd3,  32'h00000000, ALU_ADD,  12'b100000_00_000_0};
        vecs[1]  = '{32'h402081B3, 5'd1, 5'd2,  5'd3,  32'h00000000, ALU_SUB,  12'b100000_00_000_0};
        vecs[2]  = '{32'hFE000EE3, 5'd0, 5'd0,  5'd29, 32'hFFFFFFFC, ALU_SUB,  12'b000000_01_000_0};
        vecs[3]  = '{32'hFFF00093, 5'd0, 5'd31, 5'd1,  32'hFFFFFFFF, ALU_ADD,  12'b100100_00_000_0};
        vecs[4]  = '{32'h00812283, 5'd2, 5'd8,  5'd5,  32'h00000008, ALU_ADD,  12'b110100_00_001_0};
        vecs[5]  = '{32'hFE512E23, 5'd2, 5'd5,  5'd28, 32'hFFFFFFFC, ALU_ADD,  12'b001100_00_000_0};
        vecs[6]  = '{32'h001000EF, 5'd0, 5'd1,  5'd1,  32'h00000800, ALU_ADD,  12'b100000_10_010_0};
        vecs[7]  = '{32'h800003B7, 5'd0, 5'd0,  5'd7,  32'h80000000, ALU_ADD,  12'b100000_00_011_0};
        vecs[8]  = '{32'h00001397, 5'd0, 5'd0,  5'd7,  32'h00001000, ALU_ADD,  12'b100000_00_100_0};
        vecs[9]  = '{32'h00008067, 5'd1, 5'd0,  5'd0,  32'h00000000, ALU_ADD,  12'b100110_11_010_0};
        vecs[10] = '{32'h4030D093, 5'd1, 5'd3,  5'd1,  32'h00000403, ALU_SRA,  12'b100100_00_000_0};
        vecs[11] = '{32'h2030D093, 5'd1, 5'd3,  5'd1,  32'h00000203, ALU_SRL,  12'b000100_00_000_1};
        vecs[12] = '{32'hFE002EE3, 5'd0, 5'd0,  5'd29, 32'hFFFFFFFC, ALU_ADD,  12'b000000_00_000_1};
        vecs[13] = '{32'h0000000B, 5'd0, 5'd0,  5'd0,  32'h00000000, ALU_ADD,  12'b000000_00_000_1};
        vecs[14] = '{32'h4020F1B3, 5'd1, 5'd2,  5'd3,  32'h00000000, ALU_AND,  12'b000000_00_000_1};
        vecs[15] = '{32'h100322AF, 5'd6, 5'd0,  5'd5,  32'h00000000, ALU_ADD,  12'b110001_00_001_0};
        vecs[16] = '{32'h000322AF, 5'd6, 5'd0,  5'd5,  32'h00000000, ALU_ADD,  12'b000000_00_000_1};
        vecs[17] = '{32'h187322AF, 5'd6, 5'd7,  5'd5,  32'h00000000, ALU_ADD,  12'b101001_00_001_0};

        // Reset state
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_pc_imm", {out_pc, imm}, 64'd0);
        chk("rst_fields", 64'({out_valid, rs1, rs2, rd, aluOp, ctl, halt}), 64'd0);

        // LR.W with and without atomic support
        in_valid = 1'b1; in_instr = 32'h100322AF; in_pc = 32'h80;
        tick();
        in_valid = 1'b0;
        chk("lr_noatomic_illegal", 64'({a0_out_valid, a0_illegal, a0_regWr, a0_dREN}), 64'b1100);
        chk("lr_atomic_ctl", 64'({dREN, atomic, rdSel, rd, illegal}), 64'({1'b1, 1'b1, 3'd1, 5'd5, 1'b0}));
        tick();

        // Decode table, streamed back to back at full throughput
        do_reset();
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc = 32'h100 + 32'(4 * i);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
            chk($sformatf("v%0d_regs", i), 64'({rs1, rs2, rd}), 64'({vecs[i].rs1, vecs[i].rs2, vecs[i].rd}));
            chk($sformatf("v%0d_imm", i), 64'(imm), 64'(vecs[i].imm));
            chk($sformatf("v%0d_aluop", i), 64'(aluOp), 64'(vecs[i].aluop));
            chk($sformatf("v%0d_ctl", i), 64'({ctl, halt}), 64'({vecs[i].ctl, 1'b0}));
            $display("vec %0d instr=%08h pc=%08h ctl=%03h imm=%08h", i, vecs[i].instr, out_pc, ctl, imm);
        end
        in_valid = 1'b0;
        tick();
        chk("table_drained", 64'(out_valid), 64'd0);

        // Back-pressure: 6 instructions, out_ready low in cycles 2..4
        do_reset();
        pop_idx = 0;
        acc_idx = 0;
        for (int c = 0; c < 11; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid = (acc_idx < 6);
            in_instr = 32'h00100093;
            in_pc = 32'h200 + 32'(4 * acc_idx);
            chk($sformatf("bp_ready_c%0d", c), 64'(in_ready), 64'(!(c >= 3 && c <= 5)));
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order_%0d", pop_idx), 64'(out_pc), 64'(32'h200 + 32'(4 * pop_idx)));
                $display("bp cycle %0d pop pc=%08h", c, out_pc);
                pop_idx++;
            end
            if (in_valid && in_ready) acc_idx++;
            tick();
        end
        chk("bp_count", 64'(pop_idx), 64'd6);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush with H and S full and a concurrent in_valid
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
        tick();
        in_pc = 32'h404;
        tick();
        chk("fl_full_ready", 64'(in_ready), 64'd0);
        in_pc = 32'h408; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_stays_empty_%0d", k), 64'(out_valid), 64'd0);
        end

        // Flush discards an accept made in the same cycle
        do_reset();
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500; out_ready = 1'b0;
        tick();
        in_pc = 32'h504; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fla_valid", 64'(out_valid), 64'd0);
        tick();
        chk("fla_stays_empty", 64'(out_valid), 64'd0);

        // Flush clears a pending halt before it is popped
        do_reset();
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h600; out_ready = 1'b0;
        tick();
        chk("hp_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hp_flush_ready", 64'(in_ready), 64'd1);

        // Sticky halt
        do_reset();
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h300; out_ready = 1'b0;
        tick();
        in_instr = 32'h00100093; in_pc = 32'h304;
        chk("halt_out", 64'({out_valid, halt, illegal, out_pc}), 64'({1'b1, 1'b1, 1'b0, 32'h300}));
        chk("halt_pending_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("halt_popped", 64'({out_valid, in_ready}), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("halted_%0d", k), 64'({out_valid, in_ready}), 64'd0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("halted_after_flush", 64'({out_valid, in_ready}), 64'd0);
        tick();
        chk("halted_after_flush2", 64'({out_valid, in_ready}), 64'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        in_valid = 1'b0;
        chk("halt_rst_ready", 64'({out_valid, in_ready}), 64'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised decode stage that supersedes the purely combinational control decoder. It sits between fetch and execute in each core of the multi-core pipeline. It accepts one instruction per cycle over a valid/ready handshake and holds decoded entries in a 2-entry skid buffer. Beyond the old decoder it adds full sign-extended immediate generation, illegal-instruction flagging, flush, and sticky halt.

## Interface
- XLEN, 32: width of PC and immediate datapath.
- ATOMIC_EN, 1: 1 decodes LR.W/SC.W; 0 flags them illegal.
- CLK in 1: clock, rising edge.
- RST in 1: synchronous, active-high reset.
- in_valid in 1: fetch has an instruction.
- in_instr in 32: raw instruction word.
- in_pc in XLEN: PC of in_instr.
- in_ready out 1: stage can accept this cycle.
- flush in 1: discard all buffered entries.
- out_ready in 1: execute accepts the head entry.
- out_valid out 1: head entry valid.
- out_pc out XLEN: PC of head entry.
- rs1, rs2, rd out 5 each: register fields.
- imm out XLEN: sign-extended immediate, format chosen by opcode.
- aluOp out aluop_t: ALU operation.
- regWr, dREN, dWEN, aluSrc, jpSel, atomic out 1 each: control bits, same meanings as the existing control bus.
- pcSrc out 2; rdSel out 3: 0 alu, 1 memload, 2 npc, 3 LUI, 4 AUIPC.
- halt out 1: head entry is HALT.
- illegal out 1: head entry failed decode.

## Operation
- Decode rules are unchanged from the existing control bus for RTYPE, ITYPE, ITYPE_LW, JALR, STYPE, BTYPE, JAL, LUI, AUIPC, LR_SC and HALT (0xFFFFFFFF).
- Immediate formats: I = instr[31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; J = {[31],[19:12],[20],[30:21],0}; U = {[31:12],12'b0}. All are sign-extended to XLEN. Unused formats produce 0.
- Illegal conditions:
  - unknown opcode;
  - RTYPE ADD_SUB/SRL_SRA with func7 not 0x00/0x20; other RTYPE with func7 not 0x00;
  - SRLI_SRAI with imm[11:5] not 0x00/0x20;
  - BTYPE func3 010 or 011;
  - LR_SC with ATOMIC_EN=0, or func5 not LR/SC.
- An illegal entry has regWr=dREN=dWEN=halt=0, pcSrc=0, illegal=1. It still flows out as a normal entry.
- Skid buffer: head register H, skid register S.
  - in_ready = !S.valid && !halt_pending && !halted.
  - Accept = in_valid && in_ready.
  - Pop = out_valid && out_ready. On pop, H takes S if S is valid, else the newly accepted entry, else becomes invalid.
  - Accept without pop: the new entry goes to H if H is empty, else to S.
- Halt:
  - Accepting HALT sets halt_pending.
  - Popping HALT clears halt_pending and sets halted.
  - halted is sticky until RST; in_ready stays 0 while it is set.
- Flush: next cycle H and S are invalid and halt_pending=0. halted is not cleared. Any accept in the flush cycle is discarded.
- Priority: RST > flush > pop/accept.

## Timing
- Reset values: out_valid=0, in_ready=1, every decoded output and out_pc = 0, halted=0, halt_pending=0.
- Latency: accept in cycle N gives out_valid in N+1.
- Throughput: 1 per cycle while out_ready=1.
- Back-pressure:
  - out_ready low with H full: the next accept lands in S.
  - in_ready drops in the cycle after S fills.
  - No entry is ever lost or duplicated.
- Outputs are registered only; there is no combinational path from in_* to out_*. in_ready depends only on state.
- Simultaneous pop and accept with S empty: the new entry goes directly to H; out_valid stays 1.

## Structure
- Shared package cpu_types_pkg holds:
  - aluop_t and opcode_t, plus the funct3/funct5 enums (existing);
  - the new decode_bundle_t struct (all decoded fields plus pc and illegal);
  - the new rdsel constants RDSEL_ALU, RDSEL_MEM, RDSEL_NPC, RDSEL_LUI, RDSEL_AUIPC.
- Sub-module rv32_decoder: purely combinational, takes instr and produces decode_bundle_t, parametrised by XLEN and ATOMIC_EN.
- decode_stage contains only the skid buffer and the halt/flush state.

## Test plan
- Reset, then one ADD x3,x1,x2 (0x002081B3) at pc 0x100 -> next cycle: out_valid=1, rs1=1, rs2=2, rd=3, aluOp=ALU_ADD, regWr=1, out_pc=0x100, illegal=0.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, pcSrc=1, aluOp=ALU_SUB, regWr=0.
- Stream 6 sequential instructions; hold out_ready=0 for cycles 2-4 -> in_ready=0 only from cycle 3; all 6 emerge in order, none dropped or duplicated.
- With H and S full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; the flushed and concurrent instructions never appear.
- HALT (0xFFFFFFFF) followed by ADDI -> halt=1 on output; after the pop, in_ready stays 0 and the ADDI is never accepted, even across flush; RST restores in_ready=1.
- ATOMIC_EN=0, LR.W x5,(x6) (0x100322AF) -> illegal=1, regWr=0, dREN=0; with ATOMIC_EN=1 -> dREN=1, atomic=1, rdSel=1, rd=5.
